// File: rtl/dma_bus_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : dma_bus_arbiter_if                                     |
// | Description : Core-side and memory-side bus bundle for the DMA bus   |
// |               arbiter. The arbiter takes the slave view; the core +  |
// |               memory environment takes the master view.              |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface dma_bus_arbiter_if;
   // core side
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_data_o;
   logic        cpu_rw;
   logic        cpu_ready;
   logic [7:0]  cpu_data_i;
   // memory side
   logic [15:0] mem_addr;
   logic [7:0]  mem_data_o;
   logic        mem_rw;
   logic [7:0]  mem_data_i;
   // status
   logic        dma_busy;
   logic        dma_done;

   modport slave (
      input  cpu_addr, cpu_data_o, cpu_rw, mem_data_i,
      output cpu_ready, cpu_data_i, mem_addr, mem_data_o, mem_rw,
             dma_busy, dma_done
   );

   modport master (
      output cpu_addr, cpu_data_o, cpu_rw, mem_data_i,
      input  cpu_ready, cpu_data_i, mem_addr, mem_data_o, mem_rw,
             dma_busy, dma_done
   );
endinterface
`default_nettype wire

// File: rtl/dma_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : dma_bus_arbiter                                        |
// | Description : Shares the memory bus between the 6502 core and a      |
// |               page-copy DMA engine. A core write to TRIGGER_ADDR     |
// |               stalls the core and copies XFER_LEN bytes from         |
// |               {page,8'h00} to DEST_ADDR with read/write pairs.       |
// |               Optional: DMA_PARITY_ALIGN_EN inserts one ALIGN cycle  |
// |               so that every READ falls on an even parity cycle.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module dma_bus_arbiter #(
   parameter logic [15:0] TRIGGER_ADDR = 16'h4014,
   parameter logic [15:0] DEST_ADDR    = 16'h2004,
   parameter int unsigned XFER_LEN     = 256
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   dma_bus_arbiter_if.slave   bus
);

   // idx counts up to XFER_LEN (max 256), hence 9 bits
   localparam logic [8:0] LAST_IDX = 9'(XFER_LEN);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_PENDING = 3'd1,
`ifdef DMA_PARITY_ALIGN_EN
      ST_ALIGN   = 3'd2,
`endif
      ST_READ    = 3'd3,
      ST_WRITE   = 3'd4,
      ST_RESUME  = 3'd5
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [7:0] r_page;
   logic [7:0] w_page_nxt;
   logic [8:0] r_idx;
   logic [8:0] w_idx_nxt;
   logic [8:0] w_idx_inc;
   logic       w_trigger;

   assign w_trigger = !bus.cpu_rw && (bus.cpu_addr == TRIGGER_ADDR);
   assign w_idx_inc = r_idx + 9'd1;

`ifdef DMA_PARITY_ALIGN_EN
   logic r_parity;

   // Free-running cycle phase; only the alignment decision observes it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_parity <= 1'b0;
      else        r_parity <= ~r_parity;
   end
`endif

   // State, source page and byte index registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_page  <= 8'h00;
         r_idx   <= 9'd0;
      end else begin
         r_state <= w_state_nxt;
         r_page  <= w_page_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   // Next-state logic: trigger detection, halt-cycle wait and copy loop
   always_comb begin
      w_state_nxt = r_state;
      w_page_nxt  = r_page;
      w_idx_nxt   = r_idx;
      case (r_state)
         ST_IDLE, ST_RESUME: begin
            if (w_trigger) begin
               w_page_nxt  = bus.cpu_data_o;
               w_idx_nxt   = 9'd0;
               w_state_nxt = ST_PENDING;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_PENDING: begin
            // Core writes keep flowing; the first core read is the halt cycle
            if (w_trigger) begin
               w_page_nxt = bus.cpu_data_o;
            end else if (bus.cpu_rw) begin
`ifdef DMA_PARITY_ALIGN_EN
               // Next cycle parity is ~r_parity; pad if that would be odd
               w_state_nxt = r_parity ? ST_READ : ST_ALIGN;
`else
               w_state_nxt = ST_READ;
`endif
            end
         end
`ifdef DMA_PARITY_ALIGN_EN
         ST_ALIGN: begin
            w_state_nxt = ST_READ;
         end
`endif
         ST_READ: begin
            w_state_nxt = ST_WRITE;
         end
         ST_WRITE: begin
            w_idx_nxt   = w_idx_inc;
            w_state_nxt = (w_idx_inc == LAST_IDX) ? ST_RESUME : ST_READ;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Bus mux and status outputs: DMA drives memory only in ALIGN/READ/WRITE
   always_comb begin
      bus.mem_addr   = bus.cpu_addr;
      bus.mem_data_o = bus.cpu_data_o;
      bus.mem_rw     = bus.cpu_rw;
      bus.cpu_ready  = (r_state == ST_IDLE);
      bus.dma_busy   = (r_state != ST_IDLE);
      bus.dma_done   = (r_state == ST_RESUME);
      bus.cpu_data_i = bus.mem_data_i;
      case (r_state)
`ifdef DMA_PARITY_ALIGN_EN
         ST_ALIGN: begin
            bus.mem_addr = bus.cpu_addr;
            bus.mem_rw   = 1'b1;
         end
`endif
         ST_READ: begin
            // page is fixed: idx[8] never carries into the source page
            bus.mem_addr = {r_page, r_idx[7:0]};
            bus.mem_rw   = 1'b1;
         end
         ST_WRITE: begin
            // memory returns the READ byte during this cycle
            bus.mem_addr   = DEST_ADDR;
            bus.mem_rw     = 1'b0;
            bus.mem_data_o = bus.mem_data_i;
         end
         default: begin
         end
      endcase
   end

endmodule
`default_nettype wire
